select_game_sm: RTL and testbench

Game-mode selection state machine for the 65 MHz display domain. It samples the board slide switches and drives three mutually exclusive one-hot screen-select flags. The flags steer the screen renderer to the idle/menu screen, the single-player screen or the multi-player screen. It sits between the raw switch inputs and the screen-drawing logic.

---
 rtl/select_game_sm.sv | 92 +++++++++
 tb/tb_select_game_sm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_game_sm.sv
// Game-mode selector: debounced sw[1:0] request drives one-hot idle/single/multi screen flags.
// Latency 2 + STABLE_CYCLES edges from switch change to output change; no backpressure (free-running sampler).
module select_game_sm #(
    parameter int STABLE_CYCLES = 650_000
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic [15:0] sw,
    output logic        screen_idle,
    output logic        screen_single,
    output logic        screen_multi
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_MULTI  = 2'd2
    } state_e;

    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    state_e        state_q;
    state_e        state_d;
    state_e        cand;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic unused_sw;
    assign unused_sw = ^sw[15:2];

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            s1_q    <= 2'b00;
            s2_q    <= 2'b00;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= sw[1:0];
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both switches or neither means no valid choice, which falls back to the menu.
    always_comb begin
        cand = ST_IDLE;
        case (s2_q)
            2'b01:   cand = ST_SINGLE;
            2'b10:   cand = ST_MULTI;
            default: cand = ST_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!(state_q inside {ST_IDLE, ST_SINGLE, ST_MULTI})) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (cand == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = cand;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Decoded from state only; an illegal encoding shows the menu until it self-clears.
    always_comb begin
        screen_idle   = 1'b1;
        screen_single = 1'b0;
        screen_multi  = 1'b0;
        case (state_q)
            ST_SINGLE: begin
                screen_idle   = 1'b0;
                screen_single = 1'b1;
            end
            ST_MULTI: begin
                screen_idle  = 1'b0;
                screen_multi = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_select_game_sm.sv
// Bench for select_game_sm: two instances (filter length 1 and 4) checked against a history-based mode model.
module tb_select_game_sm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw1;
    logic [15:0] sw4;
    logic        idle1, single1, multi1;
    logic        idle4, single4, multi4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: recent switch samples, current mode, and run length of disagreeing requests.
    logic [1:0] hq0[$];
    logic [1:0] hq1[$];
    int         m_state[2];
    int         m_run[2];

    localparam logic [2:0] OUT_IDLE   = 3'b100;
    localparam logic [2:0] OUT_SINGLE = 3'b010;
    localparam logic [2:0] OUT_MULTI  = 3'b001;

    select_game_sm #(.STABLE_CYCLES(1)) dut1 (
        .clk65MHz(clk), .rst(rst), .sw(sw1),
        .screen_idle(idle1), .screen_single(single1), .screen_multi(multi1)
    );

    select_game_sm #(.STABLE_CYCLES(4)) dut4 (
        .clk65MHz(clk), .rst(rst), .sw(sw4),
        .screen_idle(idle4), .screen_single(single4), .screen_multi(multi4)
    );

    always #5 clk = ~clk;

    function automatic int mode_of(logic [1:0] v);
        if (v == 2'b01) return 1;
        if (v == 2'b10) return 2;
        return 0;
    endfunction

    function automatic logic [2:0] out_of(int mode);
        if (mode == 1) return OUT_SINGLE;
        if (mode == 2) return OUT_MULTI;
        return OUT_IDLE;
    endfunction

    task automatic model_reset();
        hq0 = {2'b00, 2'b00};
        hq1 = {2'b00, 2'b00};
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_run[i]   = 0;
        end
    endtask

    task automatic model_advance(int i, int req, int len);
        if (req == m_state[i]) begin
            m_run[i] = 0;
        end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == len) begin
                m_state[i] = req;
                m_run[i]   = 0;
            end
        end
    endtask

    // Request seen by the mode logic is the switch value from two edges ago.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_advance(0, mode_of(hq0[0]), 1);
            model_advance(1, mode_of(hq1[0]), 4);
            hq0.push_back(sw1[1:0]);
            hq1.push_back(sw4[1:0]);
            void'(hq0.pop_front());
            void'(hq1.pop_front());
        end
        #1;
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw1 = 16'h0000;
        sw4 = 16'h0000;
        model_reset();
        #1;
        n_checks++;
        if ({idle1, single1, multi1} !== OUT_IDLE || {idle4, single4, multi4} !== OUT_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: dut1=%b dut4=%b required %b", {idle1, single1, multi1},
                     {idle4, single4, multi4}, OUT_IDLE);
        end
        sw1 = 16'h0001;
        sw4 = 16'h0001;
        ticks(6);
        n_checks++;
        if ({idle1, single1, multi1} !== OUT_IDLE || {idle4, single4, multi4} !== OUT_IDLE) begin
            n_fail++;
            $display("FAIL reset_held: dut1=%b dut4=%b required %b", {idle1, single1, multi1},
                     {idle4, single4, multi4}, OUT_IDLE);
        end
        sw1 = 16'h0000;
        sw4 = 16'h0000;
        rst = 1'b0;
        ticks(2);
    endtask

    task automatic test_single_latency();
        logic [2:0] exp_out;
        sw1 = 16'h0001;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_out = (k >= 3) ? OUT_SINGLE : OUT_IDLE;
            n_checks++;
            if ({idle1, single1, multi1} !== exp_out) begin
                n_fail++;
                $display("FAIL single_latency edge %0d: got %b required %b", k, {idle1, single1, multi1}, exp_out);
            end
        end
    endtask

    task automatic test_multi_direct();
        logic [2:0] exp_out;
        sw1 = 16'h0002;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_out = (k >= 3) ? OUT_MULTI : OUT_SINGLE;
            n_checks++;
            if ({idle1, single1, multi1} !== exp_out) begin
                n_fail++;
                $display("FAIL multi_direct edge %0d: got %b required %b", k, {idle1, single1, multi1}, exp_out);
            end
        end
    endtask

    task automatic test_invalid_combos();
        logic [15:0] pat[6] = '{16'h0003, 16'h0000, 16'h0001, 16'hFFFC, 16'hFFFD, 16'hFFFF};
        logic [2:0]  want[6] = '{OUT_IDLE, OUT_IDLE, OUT_SINGLE, OUT_IDLE, OUT_SINGLE, OUT_IDLE};
        for (int p = 0; p < 6; p++) begin
            sw1 = pat[p];
            ticks(3);
            n_checks++;
            if ({idle1, single1, multi1} !== want[p]) begin
                n_fail++;
                $display("FAIL invalid_combo sw=%h: got %b required %b", pat[p], {idle1, single1, multi1}, want[p]);
            end
        end
        sw1 = 16'h0000;
        ticks(3);
    endtask

    task automatic test_short_pulse();
        sw4 = 16'h0001;
        ticks(3);
        sw4 = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if ({idle4, single4, multi4} !== OUT_IDLE) begin
                n_fail++;
                $display("FAIL short_pulse cycle %0d: got %b required %b", k, {idle4, single4, multi4}, OUT_IDLE);
            end
        end
    endtask

    task automatic test_hold4();
        logic [2:0] exp_out;
        sw4 = 16'h0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_out = (k >= 6) ? OUT_SINGLE : OUT_IDLE;
            n_checks++;
            if ({idle4, single4, multi4} !== exp_out) begin
                n_fail++;
                $display("FAIL hold4 edge %0d: got %b required %b", k, {idle4, single4, multi4}, exp_out);
            end
        end
        sw4 = 16'h0000;
        ticks(8);
    endtask

    // 01 then 10 is one continuous disagreement from IDLE, so the filter commits straight to MULTI.
    task automatic test_simultaneous_change();
        sw4 = 16'h0001;
        ticks(2);
        sw4 = 16'h0002;
        ticks(3);
        n_checks++;
        if ({idle4, single4, multi4} !== OUT_IDLE) begin
            n_fail++;
            $display("FAIL swap_pending: got %b required %b", {idle4, single4, multi4}, OUT_IDLE);
        end
        tick();
        n_checks++;
        if ({idle4, single4, multi4} !== OUT_MULTI) begin
            n_fail++;
            $display("FAIL swap_commit: got %b required %b", {idle4, single4, multi4}, OUT_MULTI);
        end
    endtask

    task automatic test_reset_midfilter();
        sw1 = 16'h0001;
        sw4 = 16'h0001;
        ticks(4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({idle1, single1, multi1} !== OUT_IDLE || {idle4, single4, multi4} !== OUT_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: dut1=%b dut4=%b required %b", {idle1, single1, multi1},
                     {idle4, single4, multi4}, OUT_IDLE);
        end
        ticks(2);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if ({idle4, single4, multi4} !== ((k >= 6) ? OUT_SINGLE : OUT_IDLE)) begin
                n_fail++;
                $display("FAIL reset_refilter edge %0d: got %b", k, {idle4, single4, multi4});
            end
        end
    endtask

    task automatic test_random();
        int hold;
        logic [15:0] r;
        for (int seg = 0; seg < 80; seg++) begin
            r = 16'($urandom);
            sw1 = r;
            r = 16'($urandom);
            sw4 = r;
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                tick();
                n_checks++;
                if ({idle1, single1, multi1} !== out_of(m_state[0])) begin
                    n_fail++;
                    $display("FAIL random_dut1: got %b required %b", {idle1, single1, multi1}, out_of(m_state[0]));
                end
                n_checks++;
                if ({idle4, single4, multi4} !== out_of(m_state[1])) begin
                    n_fail++;
                    $display("FAIL random_dut4: got %b required %b", {idle4, single4, multi4}, out_of(m_state[1]));
                end
                n_checks++;
                if (!$onehot({idle1, single1, multi1}) || !$onehot({idle4, single4, multi4})) begin
                    n_fail++;
                    $display("FAIL onehot: dut1=%b dut4=%b required exactly one bit", {idle1, single1, multi1},
                             {idle4, single4, multi4});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_multi_direct();
        test_invalid_combos();
        test_short_pulse();
        test_hold4();
        test_simultaneous_change();
        test_reset_midfilter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
